// File: rtl/execute_muldiv_pkg.sv
// Shared types and helpers for the execute stage with the iterative RV32M unit.
// Contents: ALU/muldiv opcode enums, control/stage-register bundles, the
// muldiv FSM state type, the single-cycle ALU function and the muldiv sign-fix
// function applied when the iterative result is finalised.
package execute_muldiv_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = $clog2(XLEN) + 1;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_t;

    // Encoding chosen so bit 2 marks divide/remainder and bit 1 (within the
    // divide group) marks remainder.
    typedef enum logic [2:0] {
        MUL    = 3'd0,
        MULH   = 3'd1,
        MULHSU = 3'd2,
        MULHU  = 3'd3,
        DIV    = 3'd4,
        DIVU   = 3'd5,
        REM    = 3'd6,
        REMU   = 3'd7
    } muldiv_op_t;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

    typedef struct packed {
        alu_op_t    alu_op;
        logic       alu_src;     // 1: operand b is imm, 0: operand b is rs2
        logic       muldiv_en;
        muldiv_op_t muldiv_op;
        logic       reg_write;
    } ctrl_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
        logic [XLEN-1:0] imm;
        logic [4:0]      rd;
        ctrl_t           ctrl;
        logic [XLEN-1:0] alu;
    } stage_regs_t;

    function automatic logic [XLEN-1:0] alu_f(input alu_op_t op,
                                              input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
        logic [XLEN-1:0] r;
        case (op)
            ALU_ADD:  r = a + b;
            ALU_SUB:  r = a - b;
            ALU_AND:  r = a & b;
            ALU_OR:   r = a | b;
            ALU_XOR:  r = a ^ b;
            ALU_SLL:  r = a << b[4:0];
            ALU_SRL:  r = a >> b[4:0];
            ALU_SRA:  r = $unsigned($signed(a) >>> b[4:0]);
            ALU_SLT:  r = {31'h0, ($signed(a) < $signed(b))};
            ALU_SLTU: r = {31'h0, (a < b)};
            default:  r = 32'h0;
        endcase
        return r;
    endfunction

    // The iterative datapath works on magnitudes; this restores the sign and
    // picks the requested half / quotient / remainder.
    function automatic logic [XLEN-1:0] fix_result(input muldiv_op_t op,
                                                   input logic [2*XLEN-1:0] acc,
                                                   input logic neg);
        logic [2*XLEN-1:0] prod;
        logic [XLEN-1:0]   sel;
        logic [XLEN-1:0]   r;
        prod = neg ? (~acc + 64'd1) : acc;
        sel  = op[1] ? acc[63:32] : acc[31:0];
        sel  = neg ? (~sel + 32'd1) : sel;
        case (op)
            MUL:                  r = prod[31:0];
            MULH, MULHSU, MULHU:  r = prod[63:32];
            DIV, DIVU, REM, REMU: r = sel;
            default:              r = 32'h0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/execute_muldiv_unit.sv
// Iterative radix-2 RV32M multiply/divide unit.
// Ports:
//   clk, reset_n      clock, async active-low reset
//   start             a live M instruction is presented
//   op, a, b          operation and raw (forwarded) operands
//   flush             kill any operation in flight; wins over everything
//   ack               result consumed by the stage register (leave DONE)
//   busy              iterating (BUSY state)
//   done              result valid in the result register (DONE state)
//   result            finished, sign-corrected 32-bit result
module execute_muldiv_unit
    import execute_muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  muldiv_op_t      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    input  logic            ack,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    md_state_t         state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [2*XLEN-1:0] acc_r;    // mul: {partial hi, multiplier}; div: {rem, dividend/quotient}
    logic [XLEN-1:0]   opnd_r;   // multiplicand or divisor magnitude
    muldiv_op_t        op_r;
    logic              neg_r;
    logic [XLEN-1:0]   res_r;

    logic              sa_s;
    logic              sb_s;
    logic              div_zero_s;
    logic              ovf_s;
    logic              special_s;
    logic              neg_s;
    logic [XLEN-1:0]   mag_a_s;
    logic [XLEN-1:0]   mag_b_s;
    logic [XLEN-1:0]   special_res_s;
    logic [XLEN:0]     sum_s;
    logic [XLEN:0]     rem_sh_s;
    logic [XLEN:0]     trial_s;
    logic [2*XLEN-1:0] acc_step_s;

    // Operand decode: signedness, magnitudes and the cases resolved without iterating.
    always_comb begin
        sa_s       = a[XLEN-1] & ((op == MULH) || (op == MULHSU) || (op == DIV) || (op == REM));
        sb_s       = b[XLEN-1] & ((op == MULH) || (op == DIV) || (op == REM));
        mag_a_s    = sa_s ? (~a + 32'd1) : a;
        mag_b_s    = sb_s ? (~b + 32'd1) : b;
        div_zero_s = op[2] && (b == 32'h0);
        ovf_s      = ((op == DIV) || (op == REM)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        special_s  = div_zero_s || ovf_s;
        // Remainder takes the dividend's sign; everything else takes the product of signs.
        neg_s      = (op[2] && op[1]) ? sa_s : (sa_s ^ sb_s);
        if (div_zero_s) begin
            special_res_s = op[1] ? a : 32'hFFFF_FFFF;
        end else if (op == DIV) begin
            special_res_s = 32'h8000_0000;
        end else begin
            special_res_s = 32'h0;
        end
    end

    // One radix-2 iteration: shift-add for multiply, restoring step for divide.
    always_comb begin
        sum_s    = {1'b0, acc_r[63:32]} + (acc_r[0] ? {1'b0, opnd_r} : 33'h0);
        rem_sh_s = acc_r[63:31];
        trial_s  = rem_sh_s - {1'b0, opnd_r};
        if (op_r[2]) begin
            if (!trial_s[XLEN]) begin
                acc_step_s = {trial_s[31:0], acc_r[30:0], 1'b1};
            end else begin
                acc_step_s = {rem_sh_s[31:0], acc_r[30:0], 1'b0};
            end
        end else begin
            acc_step_s = {sum_s, acc_r[31:1]};
        end
    end

    // Control FSM plus datapath registers; flush forces IDLE from any state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= MD_IDLE;
            cnt_r   <= '0;
            acc_r   <= '0;
            opnd_r  <= '0;
            op_r    <= MUL;
            neg_r   <= 1'b0;
            res_r   <= '0;
        end else if (flush) begin
            state_r <= MD_IDLE;
            cnt_r   <= '0;
        end else begin
            case (state_r)
                MD_IDLE: begin
                    if (start && special_s) begin
                        res_r   <= special_res_s;
                        state_r <= MD_DONE;
                    end else if (start) begin
                        acc_r   <= op[2] ? {32'h0, mag_a_s} : {32'h0, mag_b_s};
                        opnd_r  <= op[2] ? mag_b_s : mag_a_s;
                        op_r    <= op;
                        neg_r   <= neg_s;
                        cnt_r   <= '0;
                        state_r <= MD_BUSY;
                    end else begin
                        state_r <= MD_IDLE;
                    end
                end
                MD_BUSY: begin
                    acc_r <= acc_step_s;
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (cnt_r == CNT_W'(XLEN - 1)) begin
                        res_r   <= fix_result(op_r, acc_step_s, neg_r);
                        state_r <= MD_DONE;
                    end else begin
                        state_r <= MD_BUSY;
                    end
                end
                MD_DONE: begin
                    if (ack) begin
                        state_r <= MD_IDLE;
                    end else begin
                        state_r <= MD_DONE;
                    end
                end
                default: begin
                    state_r <= MD_IDLE;
                    cnt_r   <= '0;
                end
            endcase
        end
    end

    assign busy   = (state_r == MD_BUSY);
    assign done   = (state_r == MD_DONE);
    assign result = res_r;

endmodule

// File: rtl/execute_muldiv.sv
// Execute stage: single-cycle ALU for integer ops, iterative muldiv unit for
// RV32M ops, upstream stall while a muldiv op is running, and the registered
// stage bundle handed to mem.
// Ports:
//   clk, reset_n   clock, async active-low reset
//   regs_in        decoded instruction with forwarded rs1/rs2 and control
//   valid_in       regs_in holds a live instruction
//   stall_in       mem stage stall; freezes the output register
//   flush          mispredict kill from mem
//   regs_out       registered bundle to mem; alu field carries the result
//   valid_out      regs_out is live
//   stall_out      holds fetch/decode; regs_in must stay stable while high
module execute_muldiv
    import execute_muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  stage_regs_t regs_in,
    input  logic        valid_in,
    input  logic        stall_in,
    input  logic        flush,
    output stage_regs_t regs_out,
    output logic        valid_out,
    output logic        stall_out
);

    logic            m_req_s;
    logic            m_go_s;
    logic            md_busy_s;
    logic            md_done_s;
    logic            md_ack_s;
    logic            load_s;
    logic [XLEN-1:0] alu_b_s;
    logic [XLEN-1:0] alu_res_s;
    logic [XLEN-1:0] md_res_s;
    stage_regs_t     out_next_s;

    execute_muldiv_unit u_muldiv (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (m_req_s),
        .op      (regs_in.ctrl.muldiv_op),
        .a       (regs_in.rs1),
        .b       (regs_in.rs2),
        .flush   (flush),
        .ack     (md_ack_s),
        .busy    (md_busy_s),
        .done    (md_done_s),
        .result  (md_res_s)
    );

    // Stall generation, ALU, and the result mux feeding the output register.
    always_comb begin
        m_req_s   = valid_in & regs_in.ctrl.muldiv_en;
        m_go_s    = m_req_s & ~flush;
        // IDLE is the state that is neither busy nor done; DONE never stalls.
        stall_out = md_busy_s | (~md_busy_s & ~md_done_s & m_go_s);
        md_ack_s  = md_done_s & ~stall_in;
        load_s    = ~stall_in & ~stall_out;
        alu_b_s   = regs_in.ctrl.alu_src ? regs_in.imm : regs_in.rs2;
        alu_res_s = alu_f(regs_in.ctrl.alu_op, regs_in.rs1, alu_b_s);
        out_next_s     = regs_in;
        out_next_s.alu = regs_in.ctrl.muldiv_en ? md_res_s : alu_res_s;
    end

    // Output stage register; flush invalidates it even while mem is stalled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            regs_out  <= '0;
            valid_out <= 1'b0;
        end else if (flush) begin
            valid_out <= 1'b0;
        end else if (load_s) begin
            regs_out  <= out_next_s;
            valid_out <= valid_in;
        end else begin
            regs_out  <= regs_out;
            valid_out <= valid_out;
        end
    end

endmodule
